// File: rtl/md_pkg.sv
// md_pkg: shared op encodings, FSM states and constants for the multiply/divide unit
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // MULT and DIV treat operands as two's complement; the U variants do not
    function automatic logic is_signed_op(input logic [1:0] op);
        return op == MD_MULT || op == MD_DIV;
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/md_abs.sv
// md_abs: conditional two's complement, used for operand magnitude and result sign fix
module md_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] in,
    input  logic         neg,
    output logic [W-1:0] out
);

    assign out = neg ? -in : in;

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; optional MD_EARLY_OUT_EN ends multiplies early
module mult_div_unit
    import md_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    input  logic              mthi,
    input  logic              mtlo,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    md_state_e           state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc, mcand, mul_sum, fix_prod;
    logic [DATA_W-1:0]   mb, abs_a, abs_b, fix_q, fix_r;
    logic [DATA_W:0]     rem_sh, diff;
    logic                is_div, neg_q, neg_r, dz, sgn, accept, last;

    assign sgn    = is_signed_op(op);
    assign accept = state == IDLE && start;
    assign busy   = state != IDLE;

    md_abs #(.W(DATA_W)) u_abs_a (.in(srcA), .neg(sgn & srcA[DATA_W-1]), .out(abs_a));
    md_abs #(.W(DATA_W)) u_abs_b (.in(srcB), .neg(sgn & srcB[DATA_W-1]), .out(abs_b));
    md_abs #(.W(2*DATA_W)) u_fix_p (.in(acc), .neg(neg_q), .out(fix_prod));
    md_abs #(.W(DATA_W)) u_fix_q (.in(acc[DATA_W-1:0]), .neg(neg_q & ~dz), .out(fix_q));
    md_abs #(.W(DATA_W)) u_fix_r (.in(acc[2*DATA_W-1:DATA_W]), .neg(neg_r), .out(fix_r));

    // Divide keeps {remainder, quotient/dividend} in acc; multiply keeps the running product
    assign mul_sum = acc + (mb[0] ? mcand : '0);
    assign rem_sh  = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    assign diff    = rem_sh - {1'b0, mb};

`ifdef MD_EARLY_OUT_EN
    assign last = cnt == CNT_W'(MD_ITER - 1) || (!is_div && mb[DATA_W-1:1] == '0);
`else
    assign last = cnt == CNT_W'(MD_ITER - 1);
`endif

    // Next-state: IDLE -> RUN on start, RUN -> FIX after last iteration, FIX -> IDLE
    always_comb begin
        state_next = state;
        state_next = (state == IDLE) ? (start ? RUN : IDLE)
                   : (state == RUN)  ? (last ? FIX : RUN)
                   : IDLE;
    end

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Working registers: latch magnitudes and signs on accept, one shift-add or restore step per RUN cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div <= is_div_op(op);
            neg_q  <= sgn & (srcA[DATA_W-1] ^ srcB[DATA_W-1]);
            neg_r  <= sgn & srcA[DATA_W-1];
            dz     <= is_div_op(op) && srcB == '0;
            cnt    <= '0;
            mb     <= abs_b;
            mcand  <= {{DATA_W{1'b0}}, abs_a};
            acc    <= is_div_op(op) ? {{DATA_W{1'b0}}, abs_a} : '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
                acc <= diff[DATA_W] ? {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                    : {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
            end else begin
                acc   <= mul_sum;
                mcand <= mcand << 1;
                mb    <= mb >> 1;
            end
        end
    end

    // Architectural outputs: HI/LO moves in IDLE, sign-fixed result write in FIX, done pulse after it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= state == FIX;
            if (accept) begin
                div_zero <= 1'b0;
            end else if (state == IDLE) begin
                if (mthi) hi <= srcA;
                if (mtlo) lo <= srcA;
            end else if (state == FIX) begin
                hi       <= is_div ? fix_r : fix_prod[2*DATA_W-1:DATA_W];
                lo       <= is_div ? (dz ? '1 : fix_q) : fix_prod[DATA_W-1:0];
                div_zero <= dz;
            end
        end
    end

endmodule
